// File: rtl/atom_pkg.sv
// Shared types and constants for the external SRAM arbiter.
// Port indices double as the round-robin grant encoding.
package atom_pkg;

  localparam int ADDR_W = 18;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD,
    WR,
    HOLD,
    DONE
  } sram_state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pad bundle for sram_arbiter.
// slave is the arbiter side; master is the requester/pad side.
interface sram_arbiter_if #(
  parameter int ADDR_W = atom_pkg::ADDR_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_rdata;

  logic [ADDR_W-1:0] sram_adr;
  logic [7:0]        sram_dout;
  logic              sram_dout_en;
  logic [7:0]        sram_din;
  logic              ram_cs_b;
  logic              ram_oe_b;
  logic              ram_we_b;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_req, vid_addr, sram_din,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    output sram_adr, sram_dout, sram_dout_en,
    output ram_cs_b, ram_oe_b, ram_we_b
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_req, vid_addr, sram_din,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    input  sram_adr, sram_dout, sram_dout_en,
    input  ram_cs_b, ram_oe_b, ram_we_b
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant only moves when
// the grant is actually taken.
module rr_arb2
  import atom_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       grant
);

  logic last_q, last_d;

  always_comb begin
    valid = |req;
    unique case (req)
      2'b11:   grant = ~last_q;
      2'b10:   grant = PORT_VID;
      default: grant = PORT_CPU;
    endcase
    last_d = (take && valid) ? grant : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_VID;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the external 256Kx8 SRAM between the CPU port and
// the read-only video port with fixed strobe timing.
module sram_arbiter #(
  parameter int ADDR_W    = atom_pkg::ADDR_W,
  parameter int RD_CYCLES = 3,
  parameter int WE_CYCLES = 2
) (
  input logic           clk100,
  input logic           reset_n,
  sram_arbiter_if.slave bus
);

  import atom_pkg::*;

  localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WE_LAST = 8'(WE_CYCLES - 1);

  sram_state_t       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        vid_rdata_q, vid_rdata_d;
  logic              cs_b_q, cs_b_d;
  logic              oe_b_q, oe_b_d;
  logic              we_b_q, we_b_d;
  logic              den_q, den_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;
  logic              arb_valid, arb_grant, take;
  logic              is_wr;

  rr_arb2 u_arb (
    .clk   (clk100),
    .rst_n (reset_n),
    .req   ({bus.vid_req, bus.cpu_req}),
    .take  (take),
    .valid (arb_valid),
    .grant (arb_grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    take        = 1'b0;
    is_wr       = 1'b0;
    unique case (state_q)
      IDLE: if (arb_valid) begin
        take    = 1'b1;
        port_d  = arb_grant;
        is_wr   = (arb_grant == PORT_CPU) && bus.cpu_we;
        addr_d  = (arb_grant == PORT_VID) ? bus.vid_addr
                                          : bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        cnt_d   = '0;
        state_d = is_wr ? SETUP : RD;
      end
      SETUP: state_d = WR;
      RD: if (cnt_q == RD_LAST) begin
        state_d = DONE;
        if (port_q == PORT_VID) vid_rdata_d = bus.sram_din;
        else                    cpu_rdata_d = bus.sram_din;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      WR: if (cnt_q == WE_LAST) state_d = HOLD;
          else                  cnt_d   = cnt_q + 8'd1;
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes follow the next state so every pad output is a flop.
    cs_b_d    = (state_d == IDLE);
    oe_b_d    = (state_d != RD);
    we_b_d    = (state_d != WR);
    den_d     = (state_d == SETUP) || (state_d == WR) ||
                (state_d == HOLD);
    cpu_ack_d = (state_d == DONE) && (port_d == PORT_CPU);
    vid_ack_d = (state_d == DONE) && (port_d == PORT_VID);
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      port_q      <= PORT_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      cs_b_q      <= 1'b1;
      oe_b_q      <= 1'b1;
      we_b_q      <= 1'b1;
      den_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      cs_b_q      <= cs_b_d;
      oe_b_q      <= oe_b_d;
      we_b_q      <= we_b_d;
      den_q       <= den_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
    end
  end

  assign bus.sram_adr     = addr_q;
  assign bus.sram_dout    = wdata_q;
  assign bus.sram_dout_en = den_q;
  assign bus.ram_cs_b     = cs_b_q;
  assign bus.ram_oe_b     = oe_b_q;
  assign bus.ram_we_b     = we_b_q;
  assign bus.cpu_ack      = cpu_ack_q;
  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.vid_ack      = vid_ack_q;
  assign bus.vid_rdata    = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM pad model, shadow memory,
// latency/arbitration reference and a pad protocol monitor.
module tb_sram_arbiter;

  localparam int AW   = 18;
  localparam int RD_C = 3;
  localparam int WE_C = 2;
  localparam int RD_LAT = RD_C + 1;
  localparam int WR_LAT = WE_C + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW)) bus ();

  sram_arbiter #(
    .ADDR_W(AW), .RD_CYCLES(RD_C), .WE_CYCLES(WE_C)
  ) dut (
    .clk100  (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] shadow [int];
  int vectors = 0;
  int miscompares = 0;
  int cpu_acks = 0, vid_acks = 0;
  int oe_low = 0, we_low = 0, den_seen = 0;
  logic [AW-1:0] we_adr;
  logic [7:0] we_dat;
  logic prev_oe = 1'b0, prev_cack = 1'b0, prev_vack = 1'b0;
  logic [7:0] last_cpu_rd = 8'h00;
  int order[$];

  assign bus.sram_din = bus.ram_oe_b ? 8'hEE : mem[bus.sram_adr];

  always @(posedge clk)
    if (!bus.ram_cs_b && !bus.ram_we_b)
      mem[bus.sram_adr] <= bus.sram_dout;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oe = 1'b0; prev_cack = 1'b0; prev_vack = 1'b0;
    end else begin
      vectors++;
      if (!bus.ram_oe_b && bus.sram_dout_en) begin
        miscompares++;
        $display("FAIL oe_den_overlap: oe_b=%b den=%b want not both active",
                 bus.ram_oe_b, bus.sram_dout_en);
      end
      if (bus.sram_dout_en && prev_oe) begin
        miscompares++;
        $display("FAIL turnaround: den=1 right after oe_b=0, want idle gap");
      end
      if ((bus.cpu_ack && prev_cack) || (bus.vid_ack && prev_vack)) begin
        miscompares++;
        $display("FAIL ack_width: ack high 2 cycles, want 1-cycle pulse");
      end
      if (!bus.ram_we_b) begin
        we_low++; we_adr = bus.sram_adr; we_dat = bus.sram_dout;
      end
      if (!bus.ram_oe_b) oe_low++;
      if (bus.sram_dout_en) den_seen++;
      if (bus.cpu_ack) cpu_acks++;
      if (bus.vid_ack) vid_acks++;
      prev_oe = !bus.ram_oe_b;
      prev_cack = bus.cpu_ack;
      prev_vack = bus.vid_ack;
    end
  end

  task automatic cpu_access(input bit we, input logic [AW-1:0] a,
                            input logic [7:0] d, output int cyc,
                            output logic [7:0] rd);
    @(posedge clk); #1;
    bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    bus.cpu_req = 1'b1;
    cyc = 0; rd = 8'h00;
    while (1) begin
      @(negedge clk);
      if (bus.cpu_ack) begin rd = bus.cpu_rdata; break; end
      cyc++;
      if (cyc > 60) begin cyc = -1; break; end
    end
  endtask

  task automatic vid_access(input logic [AW-1:0] a, output int cyc,
                            output logic [7:0] rd);
    @(posedge clk); #1;
    bus.vid_addr = a; bus.vid_req = 1'b1;
    cyc = 0; rd = 8'h00;
    while (1) begin
      @(negedge clk);
      if (bus.vid_ack) begin rd = bus.vid_rdata; break; end
      cyc++;
      if (cyc > 60) begin cyc = -1; break; end
    end
  endtask

  task automatic cpu_release();
    @(posedge clk); #1; bus.cpu_req = 1'b0;
  endtask

  task automatic vid_release();
    @(posedge clk); #1; bus.vid_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if ({bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 111",
               {bus.ram_cs_b, bus.ram_oe_b, bus.ram_we_b});
    end
    if (bus.sram_dout_en !== 1'b0 || {bus.cpu_ack, bus.vid_ack} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_den_ack: den=%b acks=%b want 0/00",
               bus.sram_dout_en, {bus.cpu_ack, bus.vid_ack});
    end
    if (bus.cpu_rdata !== 8'h00 || bus.vid_rdata !== 8'h00 ||
        bus.sram_adr !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: rdata %h/%h adr %h want 00/00/0",
               bus.cpu_rdata, bus.vid_rdata, bus.sram_adr);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    if (bus.ram_cs_b !== 1'b1 || bus.ram_oe_b !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_reset: cs_b=%b oe_b=%b want 1/1",
               bus.ram_cs_b, bus.ram_oe_b);
    end
  endtask

  task automatic test_write_read();
    int cyc;
    logic [7:0] rd, d;
    logic [AW-1:0] a;
    int acks0;
    acks0 = cpu_acks;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 18'h01234 : (18'h10000 | 18'($urandom_range(0, 4095)));
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      we_low = 0;
      cpu_access(1'b1, a, d, cyc, rd);
      cpu_release();
      shadow[int'(a)] = d;
      if (cyc !== WR_LAT) begin
        miscompares++;
        $display("FAIL wr_latency[%0d]: got %0d want %0d", i, cyc, WR_LAT);
      end
      if (we_low !== WE_C || we_adr !== a || we_dat !== d) begin
        miscompares++;
        $display("FAIL wr_strobe[%0d]: we_low=%0d adr=%h dat=%h want %0d/%h/%h",
                 i, we_low, we_adr, we_dat, WE_C, a, d);
      end
      cpu_access(1'b0, a, 8'h00, cyc, rd);
      cpu_release();
      last_cpu_rd = shadow[int'(a)];
      if (cyc !== RD_LAT) begin
        miscompares++;
        $display("FAIL rd_latency[%0d]: got %0d want %0d", i, cyc, RD_LAT);
      end
      if (rd !== shadow[int'(a)]) begin
        miscompares++;
        $display("FAIL rd_data[%0d]: got %h want %h", i, rd, shadow[int'(a)]);
      end
    end
    if (cpu_acks - acks0 !== 10) begin
      miscompares++;
      $display("FAIL cpu_ack_count: got %0d want 10", cpu_acks - acks0);
    end
  endtask

  task automatic test_video();
    int cyc;
    logic [7:0] rd;
    logic [AW-1:0] a;
    mem[18'h08000] = 8'h3C;
    shadow[32'h08000] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 18'h08000 : (18'h30000 | 18'($urandom_range(0, 255)));
      oe_low = 0; den_seen = 0; vid_acks = 0;
      vid_access(a, cyc, rd);
      vid_release();
      repeat (3) @(negedge clk);
      if (cyc !== RD_LAT || rd !== shadow[int'(a)]) begin
        miscompares++;
        $display("FAIL vid_read[%0d]: lat=%0d data=%h want %0d/%h",
                 i, cyc, rd, RD_LAT, shadow[int'(a)]);
      end
      if (oe_low !== RD_C || den_seen !== 0 || vid_acks !== 1) begin
        miscompares++;
        $display("FAIL vid_strobes[%0d]: oe_low=%0d den=%0d acks=%0d want %0d/0/1",
                 i, oe_low, den_seen, vid_acks, RD_C);
      end
      if (bus.cpu_rdata !== last_cpu_rd) begin
        miscompares++;
        $display("FAIL cpu_rdata_hold[%0d]: got %h want %h",
                 i, bus.cpu_rdata, last_cpu_rd);
      end
    end
  endtask

  task automatic cpu_stream();
    int cyc;
    logic [7:0] rd, d;
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        a = 18'h20000 | 18'($urandom_range(0, 4095));
        d = 8'($urandom);
        cpu_access(1'b1, a, d, cyc, rd);
        shadow[int'(a)] = d;
        order.push_back(0);
        if (cyc < 0 || cyc > WR_LAT + RD_LAT + 1) begin
          miscompares++;
          $display("FAIL cpu_wait[%0d]: got %0d want <= %0d",
                   i, cyc, WR_LAT + RD_LAT + 1);
        end
      end else begin
        cpu_access(1'b0, a, 8'h00, cyc, rd);
        order.push_back(0);
        if (cyc < 0 || cyc > RD_LAT + RD_LAT + 1 || rd !== shadow[int'(a)]) begin
          miscompares++;
          $display("FAIL cpu_cont_rd[%0d]: lat=%0d data=%h want <=%0d/%h",
                   i, cyc, rd, 2 * RD_LAT + 1, shadow[int'(a)]);
        end
      end
    end
    cpu_release();
  endtask

  task automatic vid_stream();
    int cyc;
    logic [7:0] rd;
    logic [AW-1:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 18'h30000 | 18'($urandom_range(0, 255));
      vid_access(a, cyc, rd);
      order.push_back(1);
      if (cyc < 0 || cyc > RD_LAT + WR_LAT + 1 || rd !== shadow[int'(a)]) begin
        miscompares++;
        $display("FAIL vid_cont_rd[%0d]: lat=%0d data=%h want <=%0d/%h",
                 i, cyc, rd, RD_LAT + WR_LAT + 1, shadow[int'(a)]);
      end
    end
    vid_release();
  endtask

  task automatic test_contention();
    order.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fork
      cpu_stream();
      vid_stream();
    join
    if (order.size() !== 12) begin
      miscompares++;
      $display("FAIL grant_count: got %0d want 12", order.size());
    end
    foreach (order[i])
      if (order[i] !== i % 2) begin
        miscompares++;
        $display("FAIL grant_order[%0d]: got %0d want %0d", i, order[i], i % 2);
      end
  endtask

  task automatic test_reset_mid_write();
    int acks0, n, cyc;
    logic [7:0] rd;
    acks0 = cpu_acks;
    @(posedge clk); #1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 18'h2AAAA; bus.cpu_wdata = 8'h5A;
    bus.cpu_req = 1'b1;
    n = 0;
    while (bus.ram_we_b !== 1'b0 && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) begin
      miscompares++;
      $display("FAIL wr_start_timeout: we_b never low");
    end
    rst_n = 1'b0;
    #1;
    if (bus.ram_we_b !== 1'b1 || bus.sram_dout_en !== 1'b0 ||
        bus.ram_cs_b !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: we_b=%b den=%b cs_b=%b want 1/0/1",
               bus.ram_we_b, bus.sram_dout_en, bus.ram_cs_b);
    end
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    if (cpu_acks !== acks0) begin
      miscompares++;
      $display("FAIL aborted_ack: got %0d acks want 0", cpu_acks - acks0);
    end
    cpu_access(1'b0, 18'h01234, 8'h00, cyc, rd);
    cpu_release();
    if (cyc !== RD_LAT || rd !== shadow[32'h01234]) begin
      miscompares++;
      $display("FAIL read_after_abort: lat=%0d data=%h want %0d/%h",
               cyc, rd, RD_LAT, shadow[32'h01234]);
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    for (int i = 0; i < 256; i++) begin
      mem[18'h30000 + i] = 8'($urandom);
      shadow[32'h30000 + i] = mem[18'h30000 + i];
    end
    test_reset();
    test_write_read();
    test_video();
    test_contention();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
